module_sync_fifo: RTL and testbench
===================================

// Module: module_sync_fifo
// PURPOSE
//  Single-clock, parametrised FIFO for buffering between pipeline/peripheral stages
//  (UART/timer/bus bridges). Generalises the basic FIFO with an occupancy count,
//  programmable almost-full/almost-empty thresholds and a flush input.
//  Adds sticky overflow/underflow flags and selectable show-ahead (FWFT) or registered read.
// PARAMETERS
//  XLEN      32  data width in bits (>=1)
//  LENGTH    4   depth in entries; power of two, >=2
//  AF_LEVEL  LENGTH-1  almost_full asserted when count >= AF_LEVEL (1..LENGTH)
//  AE_LEVEL  1   almost_empty asserted when count <= AE_LEVEL (0..LENGTH-1)
//  FWFT      1   1: show-ahead, dout = head combinationally; 0: registered read, 1-cycle latency
// PORTS
//  clk           in   1             clock, all state updates on rising edge
//  reset         in   1             synchronous reset, ACTIVE-LOW (0 = reset)
//  flush         in   1             synchronous clear of contents and sticky flags
//  we            in   1             write request
//  re            in   1             read request (pop)
//  din           in   XLEN          write data
//  dout          out  XLEN          read data
//  dout_valid    out  1             dout holds valid data
//  empty         out  1             count == 0
//  full          out  1             count == LENGTH
//  almost_empty  out  1             count <= AE_LEVEL
//  almost_full   out  1             count >= AF_LEVEL
//  count         out  CNTW          occupancy, CNTW = $clog2(LENGTH)+1
//  overflow      out  1             sticky: write attempted while full and not popped
//  underflow     out  1             sticky: read attempted while empty
// BEHAVIOUR
//  - Reset (reset==0 at edge): pointers=0, count=0, empty=1, full=0, almost_empty=1,
//    almost_full=(AF_LEVEL==0 ? 1:0)->0, overflow=0, underflow=0, dout_valid=FWFT?0:0, dout=0
//    in FWFT=0. Memory array not reset. Reset mid-operation discards all entries.
//  - Priority per edge: reset > flush > re/we. Flush: same as reset for pointers, count,
//    flags, dout_valid; we/re in that cycle ignored; memory untouched.
//  - Accepted write: we && (!full || accepted read). Stores din at back pointer, back++.
//  - Accepted read: re && !empty. front++. Read on empty: no pointer move, underflow<=1.
//  - Write on full with no accepted read: dropped, back unchanged, overflow<=1.
//  - re&&we when full: both accepted, count unchanged, full stays 1.
//  - re&&we when empty: write accepted, read rejected (underflow<=1), count 0->1.
//  - count: +1 on write only, -1 on read only, unchanged on both/neither.
//  - Pointers $clog2(LENGTH) bits, wrap naturally LENGTH-1 -> 0.
//  - All status flags derived from registered count; valid the cycle after the edge.
//  - FWFT=1: dout = mem[front] combinationally, dout_valid = !empty; pop advances head.
//  - FWFT=0: on accepted read at edge N, dout <= mem[front], dout_valid <= 1 (cycle N+1);
//    no accepted read -> dout_valid <= 0, dout holds last value.
//  - Sticky flags clear only on reset or flush.
// STRUCTURE
//  - Package fifo_pkg: fifo_read_mode_t enum {FIFO_FWFT, FIFO_REGISTERED}, CNTW helper
//    function, shared parameter sanity checks (power-of-two, threshold ranges).
//  - Sub-module module_fifo_mem: LENGTH x XLEN storage, 1 sync write port,
//    1 async read port; top holds pointers, count, flags, read-mode logic.
//  - Elaboration-time $error on illegal LENGTH/AF_LEVEL/AE_LEVEL.
// TESTING  (XLEN=32, LENGTH=4, AF_LEVEL=3, AE_LEVEL=1; both FWFT=1 and FWFT=0 builds)
//  1 reset=0 one edge, then re=1 -> empty=1, count=0, front=0, underflow=1, dout_valid=0.
//  2 write DEADBEEF,BABABEBE,CACACACA -> count=3, almost_full=1, full=0; 4th FEEDBEEF ->
//    full=1, back wraps to 0; write 00000000 -> dropped, overflow=1, count=4.
//  3 FWFT=1: re on 4 edges -> dout DEADBEEF,BABABEBE,CACACACA,FEEDBEEF before each edge;
//    FWFT=0: same values one cycle after each pop with dout_valid=1; then empty=1.
//  4 full + re&&we din=01010101 -> count stays 4, full=1; drain yields 01010101 last.
//  5 empty + re&&we din=11111111 -> count=1, underflow=1, almost_empty=1; next re -> 11111111.
//  6 count=3, overflow=1, flush=1 with we=1 -> count=0, empty=1, overflow=0, write ignored;
//    reset=0 asserted mid-stream with count=2 -> count=0 next cycle.

Source files
------------

// File: rtl/module_sync_fifo_pkg.sv
// Shared types and parameter helpers for the single-clock FIFO slice.
// Covers the read-mode enum, the count-width function and the legality checks.
package fifo_pkg;

  typedef enum logic {
    FIFO_FWFT,
    FIFO_REGISTERED
  } fifo_read_mode_t;

  // Occupancy needs one extra bit so that "full" (count == LENGTH) is representable.
  function automatic int cntw(input int length);
    return $clog2(length) + 1;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

  function automatic bit params_ok(input int length, input int af_level, input int ae_level);
    return is_pow2(length) &&
           (af_level >= 1) && (af_level <= length) &&
           (ae_level >= 0) && (ae_level <= length - 1);
  endfunction

endpackage

// File: rtl/module_sync_fifo_if.sv
// Request/status bundle between a FIFO user (master) and the FIFO (slave).
// we/re are requests: the FIFO decides acceptance from its own occupancy; there is no ready.
interface module_sync_fifo_if
  import fifo_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int LENGTH = 4
);
  localparam int CNTW = cntw(LENGTH);

  logic            flush;
  logic            we;
  logic            re;
  logic [XLEN-1:0] din;
  logic [XLEN-1:0] dout;
  logic            dout_valid;
  logic            empty;
  logic            full;
  logic            almost_empty;
  logic            almost_full;
  logic [CNTW-1:0] count;
  logic            overflow;
  logic            underflow;

  modport master (
    output flush, we, re, din,
    input  dout, dout_valid, empty, full, almost_empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  flush, we, re, din,
    output dout, dout_valid, empty, full, almost_empty, almost_full, count, overflow, underflow
  );

endinterface

// File: rtl/module_sync_fifo_mem.sv
// LENGTH x XLEN storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module module_fifo_mem #(
  parameter int XLEN   = 32,
  parameter int LENGTH = 4,
  parameter int AW     = $clog2(LENGTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] mem [LENGTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/module_sync_fifo.sv
// Single-clock FIFO with occupancy count, programmable thresholds, flush,
// sticky overflow/underflow and selectable show-ahead or registered read.
module module_sync_fifo
  import fifo_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int LENGTH   = 4,
  parameter int AF_LEVEL = LENGTH - 1,
  parameter int AE_LEVEL = 1,
  parameter bit FWFT     = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  module_sync_fifo_if.slave  bus
);

  localparam int PW = $clog2(LENGTH);
  localparam int CNTW = cntw(LENGTH);
  localparam fifo_read_mode_t MODE = FWFT ? FIFO_FWFT : FIFO_REGISTERED;

  if (!params_ok(LENGTH, AF_LEVEL, AE_LEVEL)) begin : g_param_err
    $error("module_sync_fifo: illegal LENGTH/AF_LEVEL/AE_LEVEL combination");
  end

  logic [PW-1:0]   front;
  logic [PW-1:0]   back;
  logic [CNTW-1:0] count_q;
  logic            ovf_q;
  logic            unf_q;
  logic            is_empty;
  logic            is_full;
  logic            rd_ok;
  logic            wr_ok;
  logic            mem_we;
  logic [XLEN-1:0] head;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNTW'(LENGTH));

  // A pop in the same cycle frees a slot, so a write on full is still accepted.
  assign rd_ok  = bus.re && !is_empty;
  assign wr_ok  = bus.we && (!is_full || rd_ok);
  assign mem_we = reset && !bus.flush && wr_ok;

  always_ff @(posedge clk) begin
    if (!reset) begin
      front   <= '0;
      back    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (bus.flush) begin
      front   <= '0;
      back    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (rd_ok) front <= front + PW'(1);
      if (wr_ok) back  <= back + PW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + CNTW'(1);
        2'b01:   count_q <= count_q - CNTW'(1);
        default: count_q <= count_q;
      endcase
      if (bus.we && is_full && !rd_ok) ovf_q <= 1'b1;
      if (bus.re && is_empty)          unf_q <= 1'b1;
    end
  end

  module_fifo_mem #(
    .XLEN   (XLEN),
    .LENGTH (LENGTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (back),
    .wdata (bus.din),
    .raddr (front),
    .rdata (head)
  );

  assign bus.empty        = is_empty;
  assign bus.full         = is_full;
  assign bus.count        = count_q;
  assign bus.almost_empty = (int'(count_q) <= AE_LEVEL);
  assign bus.almost_full  = (int'(count_q) >= AF_LEVEL);
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

  if (MODE == FIFO_FWFT) begin : g_fwft
    assign bus.dout       = head;
    assign bus.dout_valid = !is_empty;
  end else begin : g_registered
    logic [XLEN-1:0] dout_q;
    logic            dv_q;

    // dout keeps the last popped word; only dout_valid says whether it is fresh.
    always_ff @(posedge clk) begin
      if (!reset) begin
        dout_q <= '0;
        dv_q   <= 1'b0;
      end else if (bus.flush) begin
        dv_q   <= 1'b0;
      end else begin
        dv_q <= rd_ok;
        if (rd_ok) dout_q <= head;
      end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dv_q;
  end

endmodule

// File: tb/tb_module_sync_fifo.sv
// Bench for module_sync_fifo: a show-ahead and a registered-read build driven in lockstep,
// checked against a queue-based reference model.
module tb_module_sync_fifo;

  // ---------------- clock / reset / stimulus signals ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        we;
  logic        re;
  logic [31:0] din;

  always #5 clk = ~clk;

  module_sync_fifo_if #(.XLEN(32), .LENGTH(4)) if1 ();
  module_sync_fifo_if #(.XLEN(32), .LENGTH(4)) if0 ();

  assign if1.flush = flush;
  assign if1.we    = we;
  assign if1.re    = re;
  assign if1.din   = din;
  assign if0.flush = flush;
  assign if0.we    = we;
  assign if0.re    = re;
  assign if0.din   = din;

  module_sync_fifo #(.XLEN(32), .LENGTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1'b1)) dut_fwft (
    .clk   (clk),
    .reset (rst_n),
    .bus   (if1)
  );

  module_sync_fifo #(.XLEN(32), .LENGTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1'b0)) dut_reg (
    .clk   (clk),
    .reset (rst_n),
    .bus   (if0)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] exp_q[$];
  bit          m_ovf;
  bit          m_unf;
  bit          m_dv;
  logic [31:0] m_dout;
  int          passed;
  int          total;

  // Advance one edge; the model consumes the inputs that the DUTs sample at that edge.
  task automatic tick();
    int n;
    bit rd;
    bit wr;
    @(posedge clk);
    if (!rst_n) begin
      exp_q.delete();
      m_ovf = 0; m_unf = 0; m_dv = 0; m_dout = '0;
    end else if (flush) begin
      exp_q.delete();
      m_ovf = 0; m_unf = 0; m_dv = 0;
    end else begin
      n  = exp_q.size();
      rd = re && (n > 0);
      wr = we && ((n < 4) || rd);
      if (we && (n == 4) && !rd) m_ovf = 1;
      if (re && (n == 0))        m_unf = 1;
      m_dv = rd;
      if (rd) m_dout = exp_q.pop_front();
      if (wr) exp_q.push_back(din);
    end
    #1;
  endtask

  task automatic idle();
    flush = 0; we = 0; re = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 0; idle(); din = '0;
    tick();
    total++; if (if1.count !== 3'd0 || if1.empty !== 1'b1 || if1.full !== 1'b0) $display("FAIL reset_status_fwft: count=%0d empty=%b full=%b want 0/1/0", if1.count, if1.empty, if1.full); else passed++;
    total++; if (if0.almost_empty !== 1'b1 || if0.almost_full !== 1'b0 || if0.overflow !== 1'b0 || if0.underflow !== 1'b0) $display("FAIL reset_flags_reg: ae=%b af=%b ovf=%b unf=%b want 1/0/0/0", if0.almost_empty, if0.almost_full, if0.overflow, if0.underflow); else passed++;
    total++; if (if0.dout !== 32'h0 || if0.dout_valid !== 1'b0 || if1.dout_valid !== 1'b0) $display("FAIL reset_dout: reg dout=%h dv=%b fwft dv=%b want 0/0/0", if0.dout, if0.dout_valid, if1.dout_valid); else passed++;
    rst_n = 1; re = 1;
    tick();
    re = 0;
    total++; if (if1.count !== 3'd0 || if1.empty !== 1'b1 || if1.underflow !== 1'b1 || if0.underflow !== 1'b1) $display("FAIL reset_read_empty: count=%0d empty=%b unf1=%b unf0=%b want 0/1/1/1", if1.count, if1.empty, if1.underflow, if0.underflow); else passed++;
    total++; if (if0.dout_valid !== 1'b0 || if1.dout_valid !== 1'b0) $display("FAIL reset_read_dv: reg=%b fwft=%b want 0/0", if0.dout_valid, if1.dout_valid); else passed++;
  endtask

  task automatic test_fill_overflow();
    logic [31:0] vals [3] = '{32'hDEADBEEF, 32'hBABABEBE, 32'hCACACACA};
    for (int i = 0; i < 3; i++) begin
      we = 1; din = vals[i];
      tick();
    end
    total++; if (if1.count !== 3'd3 || if1.almost_full !== 1'b1 || if1.full !== 1'b0) $display("FAIL fill3_fwft: count=%0d af=%b full=%b want 3/1/0", if1.count, if1.almost_full, if1.full); else passed++;
    total++; if (if0.count !== 3'd3 || if0.almost_full !== 1'b1 || if0.almost_empty !== 1'b0) $display("FAIL fill3_reg: count=%0d af=%b ae=%b want 3/1/0", if0.count, if0.almost_full, if0.almost_empty); else passed++;
    din = 32'hFEEDBEEF;
    tick();
    total++; if (if1.count !== 3'd4 || if1.full !== 1'b1 || if0.full !== 1'b1) $display("FAIL fill4: count=%0d full1=%b full0=%b want 4/1/1", if1.count, if1.full, if0.full); else passed++;
    total++; if (if1.overflow !== 1'b0) $display("FAIL fill4_no_ovf: ovf=%b want 0", if1.overflow); else passed++;
    din = 32'h00000000;
    tick();
    we = 0;
    total++; if (if1.overflow !== 1'b1 || if0.overflow !== 1'b1 || if1.count !== 3'd4) $display("FAIL overflow_drop: ovf1=%b ovf0=%b count=%0d want 1/1/4", if1.overflow, if0.overflow, if1.count); else passed++;
  endtask

  task automatic test_drain();
    logic [31:0] vals [4] = '{32'hDEADBEEF, 32'hBABABEBE, 32'hCACACACA, 32'hFEEDBEEF};
    for (int i = 0; i < 4; i++) begin
      re = 1;
      total++; if (if1.dout !== vals[i] || if1.dout_valid !== 1'b1) $display("FAIL drain_fwft[%0d]: dout=%h dv=%b want %h/1", i, if1.dout, if1.dout_valid, vals[i]); else passed++;
      tick();
      total++; if (if0.dout !== vals[i] || if0.dout_valid !== 1'b1) $display("FAIL drain_reg[%0d]: dout=%h dv=%b want %h/1", i, if0.dout, if0.dout_valid, vals[i]); else passed++;
    end
    re = 0;
    total++; if (if1.empty !== 1'b1 || if0.empty !== 1'b1 || if1.dout_valid !== 1'b0) $display("FAIL drain_empty: e1=%b e0=%b dv1=%b want 1/1/0", if1.empty, if0.empty, if1.dout_valid); else passed++;
    tick();
    total++; if (if0.dout_valid !== 1'b0 || if0.dout !== 32'hFEEDBEEF) $display("FAIL reg_hold: dv=%b dout=%h want 0/feedbeef", if0.dout_valid, if0.dout); else passed++;
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 4; i++) begin
      we = 1; din = $urandom;
      tick();
    end
    re = 1; we = 1; din = 32'h01010101;
    tick();
    we = 0;
    total++; if (if1.count !== 3'd4 || if1.full !== 1'b1 || if0.full !== 1'b1) $display("FAIL full_rw: count=%0d full1=%b full0=%b want 4/1/1", if1.count, if1.full, if0.full); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++; if (if1.dout !== exp_q[0]) $display("FAIL full_rw_drain_fwft[%0d]: dout=%h want %h", i, if1.dout, exp_q[0]); else passed++;
      tick();
      total++; if (if0.dout !== m_dout || if0.dout_valid !== 1'b1) $display("FAIL full_rw_drain_reg[%0d]: dout=%h dv=%b want %h/1", i, if0.dout, if0.dout_valid, m_dout); else passed++;
    end
    re = 0;
    total++; if (if0.dout !== 32'h01010101 || if1.empty !== 1'b1) $display("FAIL full_rw_last: dout=%h empty=%b want 01010101/1", if0.dout, if1.empty); else passed++;
  endtask

  task automatic test_empty_rw();
    flush = 1;
    tick();
    flush = 0;
    total++; if (if1.underflow !== 1'b0 || if1.overflow !== 1'b0 || if0.underflow !== 1'b0) $display("FAIL flush_sticky: unf1=%b ovf1=%b unf0=%b want 0/0/0", if1.underflow, if1.overflow, if0.underflow); else passed++;
    re = 1; we = 1; din = 32'h11111111;
    tick();
    we = 0;
    total++; if (if1.count !== 3'd1 || if1.underflow !== 1'b1 || if1.almost_empty !== 1'b1 || if1.empty !== 1'b0) $display("FAIL empty_rw: count=%0d unf=%b ae=%b empty=%b want 1/1/1/0", if1.count, if1.underflow, if1.almost_empty, if1.empty); else passed++;
    total++; if (if0.dout_valid !== 1'b0 || if0.underflow !== 1'b1) $display("FAIL empty_rw_reg: dv=%b unf=%b want 0/1", if0.dout_valid, if0.underflow); else passed++;
    total++; if (if1.dout !== 32'h11111111) $display("FAIL empty_rw_fwft_head: dout=%h want 11111111", if1.dout); else passed++;
    tick();
    re = 0;
    total++; if (if0.dout !== 32'h11111111 || if0.dout_valid !== 1'b1 || if1.empty !== 1'b1) $display("FAIL empty_rw_pop: dout=%h dv=%b empty=%b want 11111111/1/1", if0.dout, if0.dout_valid, if1.empty); else passed++;
  endtask

  task automatic test_flush_reset();
    for (int i = 0; i < 5; i++) begin
      we = 1; din = 32'hA0000000 + 32'(i);
      tick();
    end
    we = 0; re = 1;
    tick();
    re = 0;
    total++; if (if1.count !== 3'd3 || if1.overflow !== 1'b1) $display("FAIL preflush: count=%0d ovf=%b want 3/1", if1.count, if1.overflow); else passed++;
    flush = 1; we = 1; din = 32'h55555555;
    tick();
    flush = 0; we = 0;
    total++; if (if1.count !== 3'd0 || if1.empty !== 1'b1 || if1.overflow !== 1'b0 || if0.count !== 3'd0) $display("FAIL flush: count1=%0d empty=%b ovf=%b count0=%0d want 0/1/0/0", if1.count, if1.empty, if1.overflow, if0.count); else passed++;
    total++; if (if0.dout_valid !== 1'b0 || if0.dout !== 32'hA0000000) $display("FAIL flush_reg_dout: dv=%b dout=%h want 0/a0000000", if0.dout_valid, if0.dout); else passed++;
    tick();
    total++; if (if1.count !== 3'd0) $display("FAIL flush_write_ignored: count=%0d want 0", if1.count); else passed++;
    for (int i = 0; i < 2; i++) begin
      we = 1; din = $urandom;
      tick();
    end
    total++; if (if1.count !== 3'd2) $display("FAIL prereset: count=%0d want 2", if1.count); else passed++;
    rst_n = 0; we = 1; din = $urandom;
    tick();
    rst_n = 1; we = 0;
    total++; if (if1.count !== 3'd0 || if0.count !== 3'd0 || if0.dout !== 32'h0 || if1.empty !== 1'b1) $display("FAIL midreset: count1=%0d count0=%0d dout0=%h empty=%b want 0/0/0/1", if1.count, if0.count, if0.dout, if1.empty); else passed++;
  endtask

  task automatic test_random();
    int wbias;
    int n;
    for (int c = 0; c < 400; c++) begin
      wbias = ((c / 50) % 2 == 0) ? 75 : 30;
      rst_n = ($urandom_range(0, 99) >= 2);
      flush = ($urandom_range(0, 99) < 3);
      we    = ($urandom_range(0, 99) < wbias);
      re    = ($urandom_range(0, 99) < (100 - wbias));
      din   = $urandom;
      if (exp_q.size() > 0 && rst_n) begin
        total++; if (if1.dout !== exp_q[0]) $display("FAIL rnd_fwft_head c=%0d: dout=%h want %h", c, if1.dout, exp_q[0]); else passed++;
      end
      tick();
      n = exp_q.size();
      total++; if (if1.count !== 3'(n) || if0.count !== 3'(n)) $display("FAIL rnd_count c=%0d: count1=%0d count0=%0d want %0d", c, if1.count, if0.count, n); else passed++;
      total++; if (if1.empty !== (n == 0) || if1.full !== (n == 4) || if0.empty !== (n == 0) || if0.full !== (n == 4)) $display("FAIL rnd_empty_full c=%0d: e1=%b f1=%b e0=%b f0=%b want n=%0d", c, if1.empty, if1.full, if0.empty, if0.full, n); else passed++;
      total++; if (if1.almost_empty !== (n <= 1) || if1.almost_full !== (n >= 3) || if0.almost_empty !== (n <= 1) || if0.almost_full !== (n >= 3)) $display("FAIL rnd_thresholds c=%0d: ae1=%b af1=%b ae0=%b af0=%b want n=%0d", c, if1.almost_empty, if1.almost_full, if0.almost_empty, if0.almost_full, n); else passed++;
      total++; if (if1.overflow !== m_ovf || if1.underflow !== m_unf || if0.overflow !== m_ovf || if0.underflow !== m_unf) $display("FAIL rnd_sticky c=%0d: ovf1=%b unf1=%b ovf0=%b unf0=%b want %b/%b", c, if1.overflow, if1.underflow, if0.overflow, if0.underflow, m_ovf, m_unf); else passed++;
      total++; if (if1.dout_valid !== (n > 0)) $display("FAIL rnd_fwft_dv c=%0d: dv=%b want %b", c, if1.dout_valid, (n > 0)); else passed++;
      total++; if (if0.dout_valid !== m_dv || if0.dout !== m_dout) $display("FAIL rnd_reg_dout c=%0d: dv=%b dout=%h want %b/%h", c, if0.dout_valid, if0.dout, m_dv, m_dout); else passed++;
    end
    rst_n = 1; idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    passed = 0;
    total  = 0;
    m_ovf = 0; m_unf = 0; m_dv = 0; m_dout = '0;
    rst_n = 0; idle(); din = '0;
    test_reset();
    test_fill_overflow();
    test_drain();
    test_full_rw();
    test_empty_rw();
    test_flush_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
